// File: rtl/sd_req_arbiter_if.sv
// Bundle of client request/response and sd_card control/status signals shared by
// sd_req_arbiter (slave side) and whatever drives it (master side).
interface sd_req_arbiter_if;
  // Client side
  logic [3:0]   req_rd;
  logic [3:0]   req_wr;
  logic [127:0] req_sector;
  logic [31:0]  cl_inbyte;
  logic [3:0]   grant;
  logic [3:0]   ack;
  logic [3:0]   cl_outen;
  logic [8:0]   cl_outaddr;
  logic [7:0]   cl_outbyte;

  // sd_card side
  logic [3:0]   sd_rstart;
  logic [3:0]   sd_wstart;
  logic [31:0]  sd_rsector;
  logic [7:0]   sd_inbyte;
  logic         sd_rbusy;
  logic         sd_rdone;
  logic         sd_outen;
  logic [8:0]   sd_outaddr;
  logic [7:0]   sd_outbyte;

  // Arbiter view
  modport slave (
    input  req_rd, req_wr, req_sector, cl_inbyte,
    input  sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte,
    output grant, ack, cl_outen, cl_outaddr, cl_outbyte,
    output sd_rstart, sd_wstart, sd_rsector, sd_inbyte
  );

  // Client/sd_card environment view
  modport master (
    output req_rd, req_wr, req_sector, cl_inbyte,
    output sd_rbusy, sd_rdone, sd_outen, sd_outaddr, sd_outbyte,
    input  grant, ack, cl_outen, cl_outaddr, cl_outbyte,
    input  sd_rstart, sd_wstart, sd_rsector, sd_inbyte
  );
endinterface

// File: rtl/sd_req_arbiter.sv
// Four-client arbiter in front of a single sd_card controller. Define SD_ARB_ROUND_ROBIN_EN
// for round-robin selection; otherwise client 0 has fixed highest priority.
module sd_req_arbiter #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input logic             clk,
  input logic             rstn,
  sd_req_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StActive, StDone, StGap} state_e;

  localparam logic [3:0] GapLast = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  state_e      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic        rd_q, rd_d;
  logic [31:0] sector_q, sector_d;
  logic [3:0]  gap_q, gap_d;

  logic [3:0]  req_any;
  logic [1:0]  win_idx;
  logic [3:0]  win_oh;
  logic        win_rd;
  logic [31:0] win_sector;

  // Lowest set bit index; 0 when nothing is set (caller only uses it when req_any != 0).
  function automatic logic [1:0] first_set(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  assign req_any = bus.req_rd | bus.req_wr;

`ifdef SD_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] rr_base;
  logic [3:0] rr_rot;

  // Rotate so that bit 0 of rr_rot is the client just after the last winner.
  assign rr_base = ptr_q + 2'd1;

  always_comb begin
    rr_rot = req_any;
    unique case (rr_base)
      2'd0: rr_rot = req_any;
      2'd1: rr_rot = {req_any[0],   req_any[3:1]};
      2'd2: rr_rot = {req_any[1:0], req_any[3:2]};
      2'd3: rr_rot = {req_any[2:0], req_any[3]};
      default: rr_rot = req_any;
    endcase
  end

  assign win_idx = rr_base + first_set(rr_rot);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= 2'd3;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign win_idx = first_set(req_any);
`endif

  assign win_oh     = 4'b0001 << win_idx;
  assign win_rd     = bus.req_rd[win_idx];  // read wins when both directions are requested
  assign win_sector = bus.req_sector[{win_idx, 5'd0} +: 32];

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rd_d     = rd_q;
    sector_d = sector_q;
    gap_d    = gap_q;
`ifdef SD_ARB_ROUND_ROBIN_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if ((req_any != 4'b0000) && !bus.sd_rbusy) begin
          grant_d  = win_oh;
          rd_d     = win_rd;
          sector_d = win_sector;
          state_d  = StActive;
`ifdef SD_ARB_ROUND_ROBIN_EN
          ptr_d    = win_idx;
`endif
        end
      end
      StActive: begin
        if (bus.sd_rdone) state_d = StDone;
      end
      StDone: begin
        grant_d = 4'b0000;
        if (GAP_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          gap_d   = GapLast;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      grant_q  <= 4'b0000;
      rd_q     <= 1'b0;
      sector_q <= 32'h0;
      gap_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rd_q     <= rd_d;
      sector_q <= sector_d;
      gap_q    <= gap_d;
    end
  end

  // All client/sd_card strobes derive from registered state, so reset forces them low at once.
  always_comb begin
    bus.grant      = grant_q;
    bus.ack        = (state_q == StDone) ? grant_q : 4'b0000;
    bus.sd_rstart  = ((state_q == StActive) && rd_q) ? grant_q : 4'b0000;
    bus.sd_wstart  = ((state_q == StActive) && !rd_q) ? grant_q : 4'b0000;
    bus.cl_outen   = ((state_q == StActive) && rd_q && bus.sd_outen) ? grant_q : 4'b0000;
    bus.sd_rsector = sector_q;
    bus.cl_outaddr = bus.sd_outaddr;
    bus.cl_outbyte = bus.sd_outbyte;
  end

  always_comb begin
    bus.sd_inbyte = 8'h00;
    unique case (grant_q)
      4'b0001: bus.sd_inbyte = bus.cl_inbyte[7:0];
      4'b0010: bus.sd_inbyte = bus.cl_inbyte[15:8];
      4'b0100: bus.sd_inbyte = bus.cl_inbyte[23:16];
      4'b1000: bus.sd_inbyte = bus.cl_inbyte[31:24];
      default: bus.sd_inbyte = 8'h00;
    endcase
  end

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rstn) $onehot0(grant_q));

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Randomized scoreboard bench for sd_req_arbiter; honours SD_ARB_ROUND_ROBIN_EN like the DUT.
module tb_sd_req_arbiter;
  localparam int unsigned GAP = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sd_req_arbiter_if bus ();

  sd_req_arbiter #(.GAP_CYCLES(GAP)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  typedef struct {
    logic [3:0]  grant;
    bit          rd;
    logic [31:0] sector;
    logic [7:0]  inbyte;
    int          n_outen;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = 3;
  int   outen_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (timed out) at %0t", name, $time);
  endtask

  // Reference selection: first requester in search order.
  function automatic int pick(input logic [3:0] any);
`ifdef SD_ARB_ROUND_ROBIN_EN
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (model_ptr + 1 + k) % 4;
      if (any[idx]) return idx;
    end
`else
    for (int i = 0; i < 4; i++) if (any[i]) return i;
`endif
    return -1;
  endfunction

  task automatic push_exp(input int n, output exp_t e);
    int w;
    w = pick(bus.req_rd | bus.req_wr);
    e.grant   = 4'(1 << w);
    e.rd      = bus.req_rd[w];
    e.sector  = bus.req_sector[w*32 +: 32];
    e.inbyte  = bus.cl_inbyte[w*8 +: 8];
    e.n_outen = e.rd ? n : 0;
    model_ptr = w;
    exp_q.push_back(e);
  endtask

  // Monitor: checks active-phase outputs and retires one expectation per ack pulse.
  always begin
    exp_t e;
    logic [3:0] starts;
    @(posedge clk);
    #1;
    if (!rstn) begin
      outen_cnt = 0;
    end else begin
      starts = bus.sd_rstart | bus.sd_wstart;
      if (exp_q.size() == 0) begin
        if (starts != 0 || bus.ack != 0 || bus.cl_outen != 0 || bus.grant != 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_activity grant=%0h start=%0h ack=%0h outen=%0h required 0",
                   bus.grant, starts, bus.ack, bus.cl_outen);
        end
      end else begin
        e = exp_q[0];
        if (bus.cl_outen != 0) outen_cnt++;
        if (starts != 0) begin
          chk("sd_rstart", 32'(bus.sd_rstart), 32'(e.rd ? e.grant : 4'b0));
          chk("sd_wstart", 32'(bus.sd_wstart), 32'(e.rd ? 4'b0 : e.grant));
          chk("grant_active", 32'(bus.grant), 32'(e.grant));
          chk("sd_rsector", bus.sd_rsector, e.sector);
          chk("sd_inbyte", 32'(bus.sd_inbyte), 32'(e.inbyte));
          chk("cl_outen", 32'(bus.cl_outen), 32'((e.rd && bus.sd_outen) ? e.grant : 4'b0));
        end
        if (bus.ack != 0) begin
          chk("ack", 32'(bus.ack), 32'(e.grant));
          chk("grant_done", 32'(bus.grant), 32'(e.grant));
          chk("starts_done", 32'(starts), 32'h0);
          chk("outen_count", outen_cnt, e.n_outen);
          outen_cnt = 0;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic drop_reqs();
    bus.req_rd = 4'b0;
    bus.req_wr = 4'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((bus.sd_rstart | bus.sd_wstart) != 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("start_timeout");
  endtask

  // Plays the sd_card: data strobes, then sd_rdone; returns in the ack cycle (at negedge).
  task automatic finish_txn(input int n, input bit wiggle, input bit hold);
    bit ok;
    logic [8:0] a;
    logic [7:0] b;
    wait_start(ok);
    if (!ok) return;
    a = 9'($urandom);
    b = 8'($urandom);
    bus.sd_outaddr = a;
    bus.sd_outbyte = b;
    #1;
    chk("cl_outaddr", 32'(bus.cl_outaddr), 32'(a));
    chk("cl_outbyte", 32'(bus.cl_outbyte), 32'(b));
    if (wiggle) begin
      bus.req_sector = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) drop_reqs();
    end
    for (int i = 0; i < n; i++) begin
      bus.sd_outen = 1'b1;
      @(negedge clk);
      bus.sd_outen = 1'b0;
      @(negedge clk);
    end
    bus.sd_rdone = 1'b1;
    @(negedge clk);
    bus.sd_rdone = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.ack != 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) fail("ack_timeout");
    if (!hold) drop_reqs();
  endtask

  // Stray sd_rdone while not active must be ignored; grant stays clear.
  task automatic idle_gap();
    for (int i = 0; i <= GAP; i++) begin
      @(negedge clk);
      bus.sd_rdone = (i == 0);
      chk("grant_gap", 32'(bus.grant), 32'h0);
    end
    bus.sd_rdone = 1'b0;
  endtask

  task automatic do_txn(input logic [3:0] rd, input logic [3:0] wr, input logic [127:0] sec,
                        input logic [31:0] inb, input int n, input logic [3:0] want,
                        input bit directed, input bit wiggle);
    exp_t e;
    @(negedge clk);
    bus.req_rd     = rd;
    bus.req_wr     = wr;
    bus.req_sector = sec;
    bus.cl_inbyte  = inb;
    push_exp(n, e);
    @(posedge clk);
    #1;
    chk("grant_latency", 32'(bus.grant), 32'(directed ? want : e.grant));
    finish_txn(n, wiggle, 1'b0);
    idle_gap();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t       e;
    logic [3:0] want [4];
    int         cnt;
    int         acks;
    bit         ok;

    bus.req_rd     = 4'b0;
    bus.req_wr     = 4'b0;
    bus.req_sector = '0;
    bus.cl_inbyte  = 32'hFFFF_FFFF;
    bus.sd_rbusy   = 1'b0;
    bus.sd_rdone   = 1'b0;
    bus.sd_outen   = 1'b1;
    bus.sd_outaddr = 9'h0;
    bus.sd_outbyte = 8'h0;

    // Reset values
    #12;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ack", 32'(bus.ack), 32'h0);
    chk("rst_rstart", 32'(bus.sd_rstart), 32'h0);
    chk("rst_wstart", 32'(bus.sd_wstart), 32'h0);
    chk("rst_rsector", bus.sd_rsector, 32'h0);
    chk("rst_outen", 32'(bus.cl_outen), 32'h0);
    chk("rst_inbyte", 32'(bus.sd_inbyte), 32'h0);
    bus.sd_outen  = 1'b0;
    bus.cl_inbyte = 32'h0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Held all-client reads straight after reset
`ifdef SD_ARB_ROUND_ROBIN_EN
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
    want = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
`endif
    @(negedge clk);
    bus.req_rd     = 4'b1111;
    bus.req_sector = {$urandom, $urandom, $urandom, $urandom};
    push_exp(2, e);
    @(posedge clk);
    #1;
    chk("grant_held0", 32'(bus.grant), 32'(want[0]));
    for (int k = 0; k < 4; k++) begin
      finish_txn(2, 1'b0, 1'b1);
      if (k < 3) begin
        push_exp(2, e);
        cnt = 0;
        do begin
          @(posedge clk);
          #1;
          cnt++;
        end while (bus.grant == 0 && cnt < 30);
        chk("gap_len", cnt, GAP + 2);
        chk("grant_held", 32'(bus.grant), 32'(want[k+1]));
      end
    end
    drop_reqs();
    idle_gap();

    // Basic read, client 0
    do_txn(4'b0001, 4'b0000, 128'h0000_1234, 32'h0, 3, 4'b0001, 1'b1, 1'b0);

    // Write from client 2; outen must stay gated
    do_txn(4'b0000, 4'b0100, {$urandom, $urandom, $urandom, $urandom}, 32'h00A5_0000, 4,
           4'b0100, 1'b1, 1'b0);

    // Busy card holds off the grant
    @(negedge clk);
    bus.sd_rbusy = 1'b1;
    bus.req_rd   = 4'b0001;
    push_exp(1, e);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("grant_busy", 32'(bus.grant), 32'h0);
    end
    @(negedge clk);
    bus.sd_rbusy = 1'b0;
    @(posedge clk);
    #1;
    chk("grant_after_busy", 32'(bus.grant), 32'h1);
    finish_txn(1, 1'b0, 1'b0);
    idle_gap();

    // Full 512-byte read to client 2
    do_txn(4'b0100, 4'b0000, {$urandom, $urandom, $urandom, $urandom}, $urandom, 512,
           4'b0100, 1'b1, 1'b0);

    // Random traffic, including sector changes and withdrawals while active
    for (int t = 0; t < 40; t++) begin
      logic [3:0] rd;
      logic [3:0] wr;
      rd = 4'($urandom_range(0, 15));
      wr = 4'($urandom_range(0, 15));
      if ((rd | wr) == 0) rd = 4'(1 << $urandom_range(0, 3));
      do_txn(rd, wr, {$urandom, $urandom, $urandom, $urandom}, $urandom,
             $urandom_range(0, 6), 4'b0, 1'b0, 1'b1);
    end

    // Reset in the middle of a transaction
    @(negedge clk);
    bus.req_rd     = 4'b0010;
    bus.req_sector = {$urandom, $urandom, $urandom, $urandom};
    bus.cl_inbyte  = $urandom;
    push_exp(0, e);
    wait_start(ok);
    bus.sd_outen = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_ack", 32'(bus.ack), 32'h0);
    chk("mid_rst_rstart", 32'(bus.sd_rstart), 32'h0);
    chk("mid_rst_wstart", 32'(bus.sd_wstart), 32'h0);
    chk("mid_rst_rsector", bus.sd_rsector, 32'h0);
    chk("mid_rst_outen", 32'(bus.cl_outen), 32'h0);
    chk("mid_rst_inbyte", 32'(bus.sd_inbyte), 32'h0);
    exp_q.delete();
    model_ptr    = 3;
    bus.sd_outen = 1'b0;
    drop_reqs();
    @(negedge clk);
    rstn = 1'b1;
    bus.sd_rdone = 1'b1;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      bus.sd_rdone = 1'b0;
      if (bus.ack != 0) acks++;
    end
    chk("no_ack_after_reset", acks, 0);

    // Traffic after reset restarts from the reset pointer
    for (int t = 0; t < 6; t++) begin
      do_txn(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
             {$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom_range(0, 3),
             4'b0, 1'b0, 1'b0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
